ucsbece154b_branch_resolve: RTL and testbench

Execute-stage branch resolution and predictor-update unit; the write/update end of the fetch-stage branch predictor (BTB + gshare PHT + GHR). Carries each fetched instruction's prediction metadata from Fetch through Decode to Execute. Compares the metadata against the actual outcome, raises a mispredict redirect, and drives the predictor's BTB write, PHT update and GHR reset ports.

---
 rtl/ucsbece154b_branch_resolve_pkg.sv | 23 ++
 rtl/ucsbece154b_bp_meta_pipe.sv | 53 +++++
 rtl/ucsbece154b_branch_resolve.sv | 161 ++++++++++++++++
 tb/tb_ucsbece154b_branch_resolve.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// ucsbece154b_branch_resolve_pkg
//   Shared constants for the branch-resolution slice: RISC-V control-flow
//   opcodes, the IDLE/RECOVER state encoding, and opcode decode helpers.
package ucsbece154b_branch_resolve_pkg;

    localparam logic [6:0] instr_branch_op = 7'b1100011;
    localparam logic [6:0] instr_jal_op    = 7'b1101111;
    localparam logic [6:0] instr_jalr_op   = 7'b1100111;

    typedef enum logic {
        BR_IDLE    = 1'b0,
        BR_RECOVER = 1'b1
    } br_state_t;

    function automatic logic is_branch(input logic [6:0] op);
        return op == instr_branch_op;
    endfunction

    function automatic logic is_jump(input logic [6:0] op);
        return (op == instr_jal_op) || (op == instr_jalr_op);
    endfunction

endpackage

// File: rtl/ucsbece154b_bp_meta_pipe.sv
// ucsbece154b_bp_meta_pipe
//   One pipeline register for branch-prediction metadata travelling beside
//   an instruction.
//   Ports:
//     clk, reset_i                      clock, async active-high reset
//     stall_i, flush_i                  hold / kill (flush wins over stall)
//     valid_i, pc_i, pred_taken_i,
//     pred_target_i, pht_addr_i         metadata from the previous stage
//     valid_o, pc_o, pred_taken_o,
//     pred_target_o, pht_addr_o         registered metadata
module ucsbece154b_bp_meta_pipe
    import ucsbece154b_branch_resolve_pkg::*;
#(
    parameter int NUM_GHR_BITS = 5
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    input  logic [31:0]             pc_i,
    input  logic                    pred_taken_i,
    input  logic [31:0]             pred_target_i,
    input  logic [NUM_GHR_BITS-1:0] pht_addr_i,
    output logic                    valid_o,
    output logic [31:0]             pc_o,
    output logic                    pred_taken_o,
    output logic [31:0]             pred_target_o,
    output logic [NUM_GHR_BITS-1:0] pht_addr_o
);

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            valid_o       <= 1'b0;
            pc_o          <= '0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= '0;
            pht_addr_o    <= '0;
        end else if (flush_i) begin
            // A bubble only needs valid and predTaken cleared; the other
            // fields are don't-care once valid is low.
            valid_o      <= 1'b0;
            pred_taken_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o       <= valid_i;
            pc_o          <= pc_i;
            pred_taken_o  <= pred_taken_i;
            pred_target_o <= pred_target_i;
            pht_addr_o    <= pht_addr_i;
        end
    end

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// ucsbece154b_branch_resolve
//   Execute-stage branch resolution and predictor update. Carries each fetched
//   instruction's prediction F->D->E, compares it with the actual outcome,
//   raises a redirect, and drives the BTB write / PHT update / GHR reset ports.
//   Ports:
//     clk, reset_i                     clock, async active-high reset
//     pcF_i, BranchTakenF_i,
//     BTBtargetF_i, PHTreadaddressF_i  fetch-stage prediction
//     StallD_i, FlushD_i,
//     StallE_i, FlushE_i               hazard-unit controls
//     opE_i, BranchCondE_i, PCTargetE_i  execute-stage outcome
//     MispredictE_o, PCCorrectE_o      redirect (combinational)
//     BTB_we_o, BTBwriteaddress_o,
//     BTBwritedata_o                   BTB write port
//     PHTwe_o, PHTincrement_o,
//     PHTwriteaddress_o                PHT update port
//     GHRreset_o                       registered GHR clear
//   Optional: define BRANCH_STATS_EN to add branch_count_o and
//   mispredict_count_o (saturating 32-bit counters).
module ucsbece154b_branch_resolve
    import ucsbece154b_branch_resolve_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic [31:0]                        pcF_i,
    input  logic                               BranchTakenF_i,
    input  logic [31:0]                        BTBtargetF_i,
    input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
    input  logic                               StallD_i,
    input  logic                               FlushD_i,
    input  logic                               StallE_i,
    input  logic                               FlushE_i,
    input  logic [6:0]                         opE_i,
    input  logic                               BranchCondE_i,
    input  logic [31:0]                        PCTargetE_i,
    output logic                               MispredictE_o,
    output logic [31:0]                        PCCorrectE_o,
    output logic                               BTB_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic                               PHTwe_o,
    output logic                               PHTincrement_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               GHRreset_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]                        branch_count_o,
    output logic [31:0]                        mispredict_count_o
`endif
);

    localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

    logic                    valid_d, pt_d, valid_e, pt_e;
    logic [31:0]             pc_d, tgt_d, pc_e, tgt_e;
    logic [NUM_GHR_BITS-1:0] pht_d, pht_e;

    // Fetch always presents a real instruction; bubbles come from flushes.
    ucsbece154b_bp_meta_pipe #(.NUM_GHR_BITS(NUM_GHR_BITS)) u_meta_d (
        .clk          (clk),
        .reset_i      (reset_i),
        .stall_i      (StallD_i),
        .flush_i      (FlushD_i),
        .valid_i      (1'b1),
        .pc_i         (pcF_i),
        .pred_taken_i (BranchTakenF_i),
        .pred_target_i(BTBtargetF_i),
        .pht_addr_i   (PHTreadaddressF_i),
        .valid_o      (valid_d),
        .pc_o         (pc_d),
        .pred_taken_o (pt_d),
        .pred_target_o(tgt_d),
        .pht_addr_o   (pht_d)
    );

    ucsbece154b_bp_meta_pipe #(.NUM_GHR_BITS(NUM_GHR_BITS)) u_meta_e (
        .clk          (clk),
        .reset_i      (reset_i),
        .stall_i      (StallE_i),
        .flush_i      (FlushE_i),
        .valid_i      (valid_d),
        .pc_i         (pc_d),
        .pred_taken_i (pt_d),
        .pred_target_i(tgt_d),
        .pht_addr_i   (pht_d),
        .valid_o      (valid_e),
        .pc_o         (pc_e),
        .pred_taken_o (pt_e),
        .pred_target_o(tgt_e),
        .pht_addr_o   (pht_e)
    );

    br_state_t state;

    logic is_b, is_j, is_cf, actual_taken, tgt_diff, res;
    logic mispredict, btb_we, pht_we;

    always_comb begin
        is_b         = is_branch(opE_i);
        is_j         = is_jump(opE_i);
        is_cf        = is_b | is_j;
        actual_taken = is_j | (is_b & BranchCondE_i);
        tgt_diff     = tgt_e != PCTargetE_i;
        // Resolve once, in the cycle the instruction leaves E; RECOVER
        // means E holds wrong-path work.
        res          = valid_e & !StallE_i & (state == BR_IDLE);
        // A non-CF op predicted taken falls out of the first term.
        mispredict   = res & ((actual_taken != pt_e) |
                              (actual_taken & pt_e & tgt_diff));
        btb_we       = res & is_cf & actual_taken & (!pt_e | tgt_diff);
        pht_we       = res & is_b;
    end

    assign MispredictE_o     = mispredict;
    assign PCCorrectE_o      = !mispredict  ? 32'h0 :
                               actual_taken ? PCTargetE_i : pc_e + 32'd4;
    assign BTB_we_o          = btb_we;
    assign BTBwriteaddress_o = btb_we ? pc_e[BTB_IDX_W+1:2] : '0;
    assign BTBwritedata_o    = btb_we ? PCTargetE_i : 32'h0;
    assign PHTwe_o           = pht_we;
    assign PHTincrement_o    = pht_we & BranchCondE_i;
    assign PHTwriteaddress_o = pht_we ? pht_e : '0;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state      <= BR_IDLE;
            GHRreset_o <= 1'b0;
        end else begin
            case (state)
                BR_IDLE: begin
                    state      <= mispredict ? BR_RECOVER : BR_IDLE;
                    // Jumps don't touch history, so only a branch
                    // mispredict invalidates the speculative GHR.
                    GHRreset_o <= mispredict & is_b;
                end
                default: begin
                    state      <= BR_IDLE;
                    GHRreset_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            branch_count_o     <= '0;
            mispredict_count_o <= '0;
        end else begin
            if (res & is_cf && branch_count_o != 32'hFFFF_FFFF)
                branch_count_o <= branch_count_o + 32'd1;
            if (mispredict && mispredict_count_o != 32'hFFFF_FFFF)
                mispredict_count_o <= mispredict_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
module tb_ucsbece154b_branch_resolve;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] pcF_i, BTBtargetF_i, PCTargetE_i;
    logic        BranchTakenF_i, BranchCondE_i;
    logic [4:0]  PHTreadaddressF_i;
    logic        StallD_i, FlushD_i, StallE_i, FlushE_i;
    logic [6:0]  opE_i;
    logic        MispredictE_o, BTB_we_o, PHTwe_o, PHTincrement_o, GHRreset_o;
    logic [31:0] PCCorrectE_o, BTBwritedata_o;
    logic [4:0]  BTBwriteaddress_o, PHTwriteaddress_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_o, mispredict_count_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ucsbece154b_branch_resolve dut (
        .clk              (clk),
        .reset_i          (reset_i),
        .pcF_i            (pcF_i),
        .BranchTakenF_i   (BranchTakenF_i),
        .BTBtargetF_i     (BTBtargetF_i),
        .PHTreadaddressF_i(PHTreadaddressF_i),
        .StallD_i         (StallD_i),
        .FlushD_i         (FlushD_i),
        .StallE_i         (StallE_i),
        .FlushE_i         (FlushE_i),
        .opE_i            (opE_i),
        .BranchCondE_i    (BranchCondE_i),
        .PCTargetE_i      (PCTargetE_i),
        .MispredictE_o    (MispredictE_o),
        .PCCorrectE_o     (PCCorrectE_o),
        .BTB_we_o         (BTB_we_o),
        .BTBwriteaddress_o(BTBwriteaddress_o),
        .BTBwritedata_o   (BTBwritedata_o),
        .PHTwe_o          (PHTwe_o),
        .PHTincrement_o   (PHTincrement_o),
        .PHTwriteaddress_o(PHTwriteaddress_o),
        .GHRreset_o       (GHRreset_o)
`ifdef BRANCH_STATS_EN
        ,
        .branch_count_o    (branch_count_o),
        .mispredict_count_o(mispredict_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put one instruction into E with a bubble behind it in D.
    task automatic load(input logic [31:0] pc, input logic pt,
                        input logic [31:0] tgt, input logic [4:0] pht);
        FlushD_i          = 1'b0;
        pcF_i             = pc;
        BranchTakenF_i    = pt;
        BTBtargetF_i      = tgt;
        PHTreadaddressF_i = pht;
        tick();
        FlushD_i = 1'b1;
        tick();
    endtask

    task automatic set_e(input logic [6:0] op, input logic cond, input logic [31:0] tgt);
        opE_i         = op;
        BranchCondE_i = cond;
        PCTargetE_i   = tgt;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        pcF_i = '0; BranchTakenF_i = 1'b0; BTBtargetF_i = '0; PHTreadaddressF_i = '0;
        StallD_i = 1'b0; FlushD_i = 1'b1; StallE_i = 1'b0; FlushE_i = 1'b0;
        opE_i = OP_BR; BranchCondE_i = 1'b1; PCTargetE_i = 32'h80;
        #3;
        chk("rst_mispredict", {31'b0, MispredictE_o}, 32'd0);
        chk("rst_pccorrect",  PCCorrectE_o, 32'd0);
        chk("rst_btbwe",      {31'b0, BTB_we_o}, 32'd0);
        chk("rst_phtwe",      {31'b0, PHTwe_o}, 32'd0);
        chk("rst_ghr",        {31'b0, GHRreset_o}, 32'd0);
        tick();
        reset_i = 1'b0;

        // Cold taken branch, BTB miss.
        load(32'h40, 1'b0, 32'h0, 5'h0A);
        set_e(OP_BR, 1'b1, 32'h80);
        chk("cold_mispredict", {31'b0, MispredictE_o}, 32'd1);
        chk("cold_pccorrect",  PCCorrectE_o, 32'h80);
        chk("cold_btbwe",      {31'b0, BTB_we_o}, 32'd1);
        chk("cold_btbaddr",    {27'b0, BTBwriteaddress_o}, 32'd16);
        chk("cold_btbdata",    BTBwritedata_o, 32'h80);
        chk("cold_phtwe",      {31'b0, PHTwe_o}, 32'd1);
        chk("cold_phtinc",     {31'b0, PHTincrement_o}, 32'd1);
        chk("cold_phtaddr",    {27'b0, PHTwriteaddress_o}, 32'h0A);
        tick();
        chk("cold_ghr_next",   {31'b0, GHRreset_o}, 32'd1);
        chk("cold_recover_mp", {31'b0, MispredictE_o}, 32'd0);
        tick();
        chk("cold_ghr_done",   {31'b0, GHRreset_o}, 32'd0);

        // Correctly predicted not-taken branch.
        load(32'h44, 1'b0, 32'h0, 5'h03);
        set_e(OP_BR, 1'b0, 32'h90);
        chk("nt_mispredict", {31'b0, MispredictE_o}, 32'd0);
        chk("nt_pccorrect",  PCCorrectE_o, 32'd0);
        chk("nt_btbwe",      {31'b0, BTB_we_o}, 32'd0);
        chk("nt_phtwe",      {31'b0, PHTwe_o}, 32'd1);
        chk("nt_phtinc",     {31'b0, PHTincrement_o}, 32'd0);
        chk("nt_phtaddr",    {27'b0, PHTwriteaddress_o}, 32'h03);
        tick();

        // jalr target mismatch, with FlushE_i in the same cycle.
        load(32'h50, 1'b1, 32'h100, 5'h07);
        FlushE_i = 1'b1;
        set_e(OP_JALR, 1'b0, 32'h200);
        chk("tm_mispredict", {31'b0, MispredictE_o}, 32'd1);
        chk("tm_pccorrect",  PCCorrectE_o, 32'h200);
        chk("tm_btbwe",      {31'b0, BTB_we_o}, 32'd1);
        chk("tm_btbaddr",    {27'b0, BTBwriteaddress_o}, 32'd20);
        chk("tm_btbdata",    BTBwritedata_o, 32'h200);
        chk("tm_phtwe",      {31'b0, PHTwe_o}, 32'd0);
        tick();
        FlushE_i = 1'b0;
        chk("tm_ghr", {31'b0, GHRreset_o}, 32'd0);
        tick();

        // Correct taken branch held by StallE_i for 3 cycles.
        load(32'h48, 1'b1, 32'h70, 5'h11);
        StallE_i = 1'b1;
        set_e(OP_BR, 1'b1, 32'h70);
        for (int i = 0; i < 3; i++) begin
            chk("stall_phtwe", {31'b0, PHTwe_o}, 32'd0);
            if (i < 2) tick();
        end
        tick();
        StallE_i = 1'b0;
        #1;
        chk("stall_rel_phtwe",   {31'b0, PHTwe_o}, 32'd1);
        chk("stall_rel_phtaddr", {27'b0, PHTwriteaddress_o}, 32'h11);
        chk("stall_rel_mp",      {31'b0, MispredictE_o}, 32'd0);
        tick();
        chk("stall_after_phtwe", {31'b0, PHTwe_o}, 32'd0);

        // BTB alias on an add, then a back-to-back jal masked by RECOVER.
        FlushD_i = 1'b0;
        pcF_i = 32'h60; BranchTakenF_i = 1'b1; BTBtargetF_i = 32'h99; PHTreadaddressF_i = 5'h02;
        tick();
        pcF_i = 32'h64; BranchTakenF_i = 1'b0; BTBtargetF_i = 32'h0;
        tick();
        FlushD_i = 1'b1;
        set_e(OP_ADD, 1'b0, 32'h0);
        chk("alias_mispredict", {31'b0, MispredictE_o}, 32'd1);
        chk("alias_pccorrect",  PCCorrectE_o, 32'h64);
        chk("alias_btbwe",      {31'b0, BTB_we_o}, 32'd0);
        chk("alias_phtwe",      {31'b0, PHTwe_o}, 32'd0);
        tick();
        set_e(OP_JAL, 1'b0, 32'h300);
        chk("b2b_mispredict", {31'b0, MispredictE_o}, 32'd0);
        chk("b2b_pccorrect",  PCCorrectE_o, 32'd0);
        chk("b2b_btbwe",      {31'b0, BTB_we_o}, 32'd0);
        chk("b2b_ghr",        {31'b0, GHRreset_o}, 32'd0);
        tick();

        // Async reset in the middle of RECOVER.
        load(32'h40, 1'b0, 32'h0, 5'h01);
        set_e(OP_BR, 1'b1, 32'h80);
        chk("rr_mispredict", {31'b0, MispredictE_o}, 32'd1);
        tick();
        chk("rr_ghr_before", {31'b0, GHRreset_o}, 32'd1);
        #1;
        reset_i = 1'b1;
        #1;
        chk("rr_ghr",        {31'b0, GHRreset_o}, 32'd0);
        chk("rr_mispredict0", {31'b0, MispredictE_o}, 32'd0);
        chk("rr_pccorrect",  PCCorrectE_o, 32'd0);
        chk("rr_btbwe",      {31'b0, BTB_we_o}, 32'd0);
        chk("rr_phtwe",      {31'b0, PHTwe_o}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("rr_branch_cnt", branch_count_o, 32'd0);
        chk("rr_mp_cnt",     mispredict_count_o, 32'd0);
`endif
        tick();
        reset_i = 1'b0;

        // pc+4 wraps at the top of the address space.
        load(32'hFFFF_FFFC, 1'b1, 32'h10, 5'h00);
        set_e(OP_ADD, 1'b0, 32'h0);
        chk("wrap_mispredict", {31'b0, MispredictE_o}, 32'd1);
        chk("wrap_pccorrect",  PCCorrectE_o, 32'h0);
        tick();
        tick();

        // Normal operation resumes after reset.
        load(32'h44, 1'b0, 32'h0, 5'h05);
        set_e(OP_BR, 1'b0, 32'h90);
        chk("post_mispredict", {31'b0, MispredictE_o}, 32'd0);
        chk("post_phtwe",      {31'b0, PHTwe_o}, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
